// File: rtl/keypad_scan_ctrl_if.sv
// Keypad scanner pin/event bundle: row/column pins plus the press-event port.
// Latency: none, wires only.
// Backpressure: evt_valid/evt_ready handshake; the master holds the event until it is accepted.
interface keypad_scan_ctrl_if #(
   parameter int ROWS = 4,
   parameter int COLS = 4
) ();
   localparam int CODE_W = $clog2(ROWS * COLS);

   logic [ROWS-1:0]   fila;
   logic [COLS-1:0]   col;
   logic [CODE_W-1:0] evt_code;
   logic              evt_valid;
   logic              evt_ready;
   logic              evt_overrun;
   logic              key_held;
   logic              multi_key;

   // Scanner side
   modport master (
      input  fila, evt_ready,
      output col, evt_code, evt_valid, evt_overrun, key_held, multi_key
   );

   // Keypad pins plus digit-entry consumer side
   modport slave (
      output fila, evt_ready,
      input  col, evt_code, evt_valid, evt_overrun, key_held, multi_key
   );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner: one-hot column drive, 2-flop row sync, per-frame debounce, one event per new press.
// Latency: accept 1 cycle after the qualifying frame ends; press-to-event <= (DEBOUNCE+1)*COLS*SCAN_DIV+3.
// Backpressure: one pending event; a press arriving while it is unaccepted is dropped and sets sticky evt_overrun.
module keypad_scan_ctrl #(
   parameter int  ROWS     = 4,
   parameter int  COLS     = 4,
   parameter int  SCAN_DIV = 4,
   parameter int  DEBOUNCE = 3,
   localparam int CODE_W   = $clog2(ROWS * COLS)
) (
   input  logic              clk,
   input  logic              rst_n,
   keypad_scan_ctrl_if.master bus
);
   localparam int NK     = ROWS * COLS;
   localparam int CIDX_W = $clog2(COLS);
   localparam int DW     = $clog2(SCAN_DIV);
   localparam int SW     = 4;

   typedef enum logic [1:0] {
      ST_NONE   = 2'd0,
      ST_SINGLE = 2'd1,
      ST_MULTI  = 2'd2
   } kind_e;

   // Row synchroniser
   logic [ROWS-1:0]   sync1_q, sync1_d;
   logic [ROWS-1:0]   sync2_q, sync2_d;
   // Column scan
   logic [DW-1:0]     dwell_q, dwell_d;
   logic [CIDX_W-1:0] cidx_q, cidx_d;
   logic [NK-1:0]     acc_q, acc_d;
   logic              frame_done_q, frame_done_d;
   logic              dwell_end;
   // Frame classification and debounce
   kind_e             cls_kind;
   logic [CODE_W-1:0] cls_code;
   kind_e             prev_kind_q, prev_kind_d;
   logic [CODE_W-1:0] prev_code_q, prev_code_d;
   logic [SW-1:0]     stable_q, stable_d;
   logic              accept;
   // Accepted state
   kind_e             state_q, state_d;
   logic [CODE_W-1:0] state_code_q, state_code_d;
   logic              press_evt;
   logic              key_held_w;
   logic              multi_key_w;
   // Event port
   logic              evt_valid_q, evt_valid_d;
   logic [CODE_W-1:0] evt_code_q, evt_code_d;
   logic              overrun_q, overrun_d;
   logic              hs;

   // Synchroniser, dwell counter, column index and frame accumulator registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         dwell_q      <= '0;
         cidx_q       <= '0;
         acc_q        <= '0;
         frame_done_q <= 1'b0;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         dwell_q      <= dwell_d;
         cidx_q       <= cidx_d;
         acc_q        <= acc_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Scan sequencing: capture the synced rows of the driven column at dwell end, then advance the column
   always_comb begin
      sync1_d      = bus.fila;
      sync2_d      = sync1_q;
      dwell_end    = (dwell_q == DW'(SCAN_DIV - 1));
      dwell_d      = dwell_end ? '0 : dwell_q + DW'(1);
      cidx_d       = cidx_q;
      acc_d        = acc_q;
      frame_done_d = 1'b0;
      if (dwell_end) begin
         cidx_d       = (cidx_q == CIDX_W'(COLS - 1)) ? '0 : cidx_q + CIDX_W'(1);
         frame_done_d = (cidx_q == CIDX_W'(COLS - 1));
         for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
               if (CIDX_W'(c) == cidx_q) begin
                  acc_d[r*COLS + c] = sync2_q[r];
               end
            end
         end
      end
   end

   // Classify the completed frame; acc_q is whole during the cycle after frame_done
   always_comb begin
      logic [1:0] n;
      n        = 2'd0;
      cls_code = '0;
      for (int i = 0; i < NK; i++) begin
         if (acc_q[i]) begin
            if (n == 2'd0) begin
               n        = 2'd1;
               cls_code = CODE_W'(i);
            end else begin
               n = 2'd2;
            end
         end
      end
      case (n)
         2'd0:    cls_kind = ST_NONE;
         2'd1:    cls_kind = ST_SINGLE;
         default: begin
            cls_kind = ST_MULTI;
            cls_code = '0;
         end
      endcase
   end

   // Debounce bookkeeping registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_kind_q <= ST_NONE;
         prev_code_q <= '0;
         stable_q    <= '0;
      end else begin
         prev_kind_q <= prev_kind_d;
         prev_code_q <= prev_code_d;
         stable_q    <= stable_d;
      end
   end

   // Count consecutive identical frames, saturating at DEBOUNCE; accept when stable and different
   always_comb begin
      prev_kind_d = prev_kind_q;
      prev_code_d = prev_code_q;
      stable_d    = stable_q;
      accept      = 1'b0;
      if (frame_done_q) begin
         prev_kind_d = cls_kind;
         prev_code_d = cls_code;
         if ((cls_kind == prev_kind_q) && (cls_code == prev_code_q)) begin
            stable_d = (stable_q >= SW'(DEBOUNCE)) ? SW'(DEBOUNCE) : stable_q + SW'(1);
         end else begin
            stable_d = SW'(1);
         end
         accept = (stable_d == SW'(DEBOUNCE)) &&
                  ((cls_kind != state_q) || (cls_code != state_code_q));
      end
   end

   // Accepted-state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_NONE;
         state_code_q <= '0;
      end else begin
         state_q      <= state_d;
         state_code_q <= state_code_d;
      end
   end

   // Accepted-state next state: follow the qualified classification
   always_comb begin
      state_d      = state_q;
      state_code_d = state_code_q;
      if (accept) begin
         state_d      = cls_kind;
         state_code_d = cls_code;
      end
   end

   // Accepted-state outputs; any accepted move into SINGLE is a new press
   always_comb begin
      key_held_w  = (state_q == ST_SINGLE);
      multi_key_w = (state_q == ST_MULTI);
      press_evt   = accept && (cls_kind == ST_SINGLE);
   end

   // Event port registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_valid_q <= 1'b0;
         evt_code_q  <= '0;
         overrun_q   <= 1'b0;
      end else begin
         evt_valid_q <= evt_valid_d;
         evt_code_q  <= evt_code_d;
         overrun_q   <= overrun_d;
      end
   end

   // Single-entry event holder: handshake frees it, a press into a busy holder is dropped as overrun
   always_comb begin
      hs          = evt_valid_q & bus.evt_ready;
      evt_valid_d = evt_valid_q;
      evt_code_d  = evt_code_q;
      overrun_d   = overrun_q;
      if (hs) begin
         evt_valid_d = 1'b0;
         overrun_d   = 1'b0;
      end
      if (press_evt) begin
         if (!evt_valid_q || hs) begin
            evt_valid_d = 1'b1;
            evt_code_d  = cls_code;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   assign bus.col         = COLS'(1) << cidx_q;
   assign bus.evt_code    = evt_code_q;
   assign bus.evt_valid   = evt_valid_q;
   assign bus.evt_overrun = overrun_q;
   assign bus.key_held    = key_held_w;
   assign bus.multi_key   = multi_key_w;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a 4x4 switch-matrix model driving the row lines.
// Latency: checks exact frame timing of the first accept after reset.
// Backpressure: drives evt_ready explicitly to exercise hold, handshake and overrun.
module tb_keypad_scan_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] keys;
   int          total = 0;
   int          bad   = 0;

   keypad_scan_ctrl_if #(.ROWS(4), .COLS(4)) bus ();

   keypad_scan_ctrl #(
      .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Switch matrix: a closed key at (r,c) connects column c drive to row r
   always_comb begin
      bus.fila = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (keys[r*4 + c] && bus.col[c]) bus.fila[r] = 1'b1;
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_evt(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max && !ok; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.evt_valid) ok = 1'b1;
      end
   endtask

   task automatic ack();
      bus.evt_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.evt_ready = 1'b0;
   endtask

   task automatic test_reset();
      bit any_out;
      logic [3:0] exp_col;
      keys = '0;
      bus.evt_ready = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (bus.col !== 4'b0001) begin bad++; $display("FAIL reset_col got=%b want=0001", bus.col); end
      total++; if (bus.evt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.evt_valid); end
      total++; if (bus.evt_code !== 4'd0) begin bad++; $display("FAIL reset_code got=%0d want=0", bus.evt_code); end
      total++; if (bus.evt_overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", bus.evt_overrun); end
      total++; if (bus.key_held !== 1'b0) begin bad++; $display("FAIL reset_held got=%b want=0", bus.key_held); end
      total++; if (bus.multi_key !== 1'b0) begin bad++; $display("FAIL reset_multi got=%b want=0", bus.multi_key); end
      rst_n = 1'b1;
      any_out = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         @(negedge clk);
         exp_col = 4'b0001 << ((k / 4) % 4);
         total++;
         if (bus.col !== exp_col) begin bad++; $display("FAIL idle_col cycle=%0d got=%b want=%b", k, bus.col, exp_col); end
         if (bus.evt_valid || bus.evt_overrun || bus.key_held || bus.multi_key) any_out = 1'b1;
      end
      repeat (60) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.evt_valid || bus.evt_overrun || bus.key_held || bus.multi_key) any_out = 1'b1;
      end
      total++; if (any_out !== 1'b0) begin bad++; $display("FAIL idle_outputs got=%b want=0", any_out); end
   endtask

   task automatic test_single_press();
      bit seen;
      keys = '0;
      keys[9] = 1'b1;
      do_reset();
      repeat (48) @(posedge clk);
      @(negedge clk);
      total++; if (bus.evt_valid !== 1'b0) begin bad++; $display("FAIL press_early got=%b want=0", bus.evt_valid); end
      @(posedge clk);
      @(negedge clk);
      total++; if (bus.evt_valid !== 1'b1) begin bad++; $display("FAIL press_valid got=%b want=1", bus.evt_valid); end
      total++; if (bus.evt_code !== 4'd9) begin bad++; $display("FAIL press_code got=%0d want=9", bus.evt_code); end
      total++; if (bus.key_held !== 1'b1) begin bad++; $display("FAIL press_held got=%b want=1", bus.key_held); end
      total++; if (bus.multi_key !== 1'b0) begin bad++; $display("FAIL press_multi got=%b want=0", bus.multi_key); end
      ack();
      total++; if (bus.evt_valid !== 1'b0) begin bad++; $display("FAIL press_ack got=%b want=0", bus.evt_valid); end
      seen = 1'b0;
      repeat (64) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.evt_valid) seen = 1'b1;
      end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL held_repeat got=%b want=0", seen); end
      total++; if (bus.key_held !== 1'b1) begin bad++; $display("FAIL held_still got=%b want=1", bus.key_held); end
   endtask

   task automatic test_bounce();
      bit seen, ok;
      keys = '0;
      keys[9] = 1'b1;
      do_reset();
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.evt_valid) seen = 1'b1;
         if (i % 10 == 9) keys[9] = ~keys[9];
      end
      keys[9] = 1'b1;
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL bounce_event got=%b want=0", seen); end
      wait_evt(150, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL bounce_timeout got=%b want=1", ok); end
      total++; if (bus.evt_code !== 4'd9) begin bad++; $display("FAIL bounce_code got=%0d want=9", bus.evt_code); end
      ack();
      seen = 1'b0;
      repeat (80) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.evt_valid) seen = 1'b1;
      end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL bounce_second got=%b want=0", seen); end
   endtask

   task automatic test_multi();
      bit seen, ok;
      keys = '0;
      keys[0] = 1'b1;
      keys[5] = 1'b1;
      do_reset();
      seen = 1'b0;
      repeat (60) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.evt_valid) seen = 1'b1;
      end
      total++; if (bus.multi_key !== 1'b1) begin bad++; $display("FAIL multi_flag got=%b want=1", bus.multi_key); end
      total++; if (bus.key_held !== 1'b0) begin bad++; $display("FAIL multi_held got=%b want=0", bus.key_held); end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL multi_event got=%b want=0", seen); end
      keys[5] = 1'b0;
      wait_evt(80, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL multi_release_timeout got=%b want=1", ok); end
      total++; if (bus.evt_code !== 4'd0) begin bad++; $display("FAIL multi_release_code got=%0d want=0", bus.evt_code); end
      total++; if (bus.key_held !== 1'b1) begin bad++; $display("FAIL multi_release_held got=%b want=1", bus.key_held); end
      total++; if (bus.multi_key !== 1'b0) begin bad++; $display("FAIL multi_release_flag got=%b want=0", bus.multi_key); end
      ack();
   endtask

   task automatic test_overrun();
      bit ok;
      keys = '0;
      keys[3] = 1'b1;
      bus.evt_ready = 1'b0;
      do_reset();
      wait_evt(80, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL ovr_first_timeout got=%b want=1", ok); end
      total++; if (bus.evt_code !== 4'd3) begin bad++; $display("FAIL ovr_first_code got=%0d want=3", bus.evt_code); end
      total++; if (bus.evt_overrun !== 1'b0) begin bad++; $display("FAIL ovr_first_flag got=%b want=0", bus.evt_overrun); end
      keys = '0;
      repeat (64) @(negedge clk);
      keys[7] = 1'b1;
      repeat (80) @(negedge clk);
      total++; if (bus.evt_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b want=1", bus.evt_valid); end
      total++; if (bus.evt_code !== 4'd3) begin bad++; $display("FAIL ovr_code got=%0d want=3", bus.evt_code); end
      total++; if (bus.evt_overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b want=1", bus.evt_overrun); end
      total++; if (bus.key_held !== 1'b1) begin bad++; $display("FAIL ovr_held got=%b want=1", bus.key_held); end
      ack();
      total++; if (bus.evt_valid !== 1'b0) begin bad++; $display("FAIL ovr_ack_valid got=%b want=0", bus.evt_valid); end
      total++; if (bus.evt_overrun !== 1'b0) begin bad++; $display("FAIL ovr_ack_flag got=%b want=0", bus.evt_overrun); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      keys = '0;
      keys[9] = 1'b1;
      do_reset();
      wait_evt(80, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL rmid_pre_timeout got=%b want=1", ok); end
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++; if (bus.col !== 4'b0001) begin bad++; $display("FAIL rmid_col got=%b want=0001", bus.col); end
      total++; if (bus.evt_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b want=0", bus.evt_valid); end
      total++; if (bus.key_held !== 1'b0) begin bad++; $display("FAIL rmid_held got=%b want=0", bus.key_held); end
      total++; if (bus.evt_code !== 4'd0) begin bad++; $display("FAIL rmid_code got=%0d want=0", bus.evt_code); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (48) @(posedge clk);
      @(negedge clk);
      total++; if (bus.evt_valid !== 1'b0) begin bad++; $display("FAIL rmid_early got=%b want=0", bus.evt_valid); end
      @(posedge clk);
      @(negedge clk);
      total++; if (bus.evt_valid !== 1'b1) begin bad++; $display("FAIL rmid_requal got=%b want=1", bus.evt_valid); end
      total++; if (bus.evt_code !== 4'd9) begin bad++; $display("FAIL rmid_requal_code got=%0d want=9", bus.evt_code); end
      ack();
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_bounce();
      test_multi();
      test_overrun();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Parametrised matrix-keypad scanner with debounce, key-code encoding and a valid/ready event port. It drives one column at a time, samples the row lines through a synchroniser and qualifies a key over several full frames. Each newly pressed key is reported once, and held/multi-key status is kept. It sits between the keypad pins and the digit-entry logic, replacing the fixed 4x4 free-running column driver.

## Interface
- ROWS, 4, number of row inputs (2..8)
- COLS, 4, number of column outputs (2..8)
- SCAN_DIV, 4, clock cycles each column is driven (dwell); minimum 3
- DEBOUNCE, 3, consecutive identical frames required to accept a change (1..15)
- CODE_W, clog2(ROWS*COLS), key-code width (derived, not overridden)

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- fila  in  ROWS  row lines, active-high, asynchronous to clk
- col  out  COLS  one-hot column drive, active-high
- evt_code  out  CODE_W  code of accepted press: row*COLS + column
- evt_valid  out  1  press event pending
- evt_ready  in  1  consumer accepts event
- evt_overrun  out  1  a press was dropped while an event was pending
- key_held  out  1  a single key is currently accepted as pressed
- multi_key  out  1  qualified frame shows two or more keys

## Operation
- Reset (async, rst_n=0): col = 1 (column 0), evt_code = 0, evt_valid = 0, evt_overrun = 0, key_held = 0, multi_key = 0. Dwell counter, synchroniser, frame accumulator and debounce counter are cleared. Accepted state is NONE.
- Scanning:
  - fila passes a 2-flop synchroniser.
  - The dwell counter counts 0..SCAN_DIV-1. On its last count the synchronised rows are captured into the accumulator for the current column, and col rotates left one-hot, wrapping from bit COLS-1 to bit 0.
  - Capturing column COLS-1 ends the frame and pulses frame_done internally.
- Frame classification:
  - zero bits set -> NONE
  - exactly one bit set -> SINGLE(code)
  - more than one -> MULTI
- Debounce:
  - If the classification equals the previous frame's, stable_cnt increments, saturating at DEBOUNCE. Otherwise stable_cnt = 1.
  - When stable_cnt reaches DEBOUNCE and the classification differs from the accepted state, the accepted state is updated.
- Accepted-state transitions:
  - NONE/MULTI -> SINGLE(c): key_held=1, multi_key=0, press event with code c.
  - SINGLE(a) -> SINGLE(b), b≠a: press event with b.
  - any -> NONE: key_held=0, multi_key=0, no event.
  - any -> MULTI: multi_key=1, key_held=0, no event. The code is not reported.
- Event port:
  - On a press event with evt_valid=0: evt_code=c, evt_valid=1.
  - evt_valid and evt_code hold until a cycle with evt_valid & evt_ready. The next cycle has evt_valid=0, and evt_overrun is cleared in that same cycle.
  - A press event while evt_valid=1 and no handshake in that cycle is dropped. The old code is kept and evt_overrun=1 (sticky).
  - A press event in the same cycle as the handshake loads the new code; evt_valid stays 1 and no overrun is flagged.
- A held key never repeats; only accepted-state changes generate events.

## Timing
- Frame period is COLS*SCAN_DIV cycles. col changes only on the dwell-end edge.
- The row sample at a dwell end reflects fila 2 cycles earlier, so rows must settle within SCAN_DIV-2 cycles of a column change.
- Accepted state, key_held and multi_key update 1 cycle after the frame_done edge of the qualifying frame.
- evt_valid rises in that same cycle.
- Press-to-event latency is at most (DEBOUNCE+1)*COLS*SCAN_DIV + 3 cycles.
- Reset mid-frame aborts the frame, drops any pending event and restarts at column 0 with stable_cnt=0.
- DEBOUNCE=1 accepts on the first frame after a change.

## Test plan
- Config ROWS=COLS=4, SCAN_DIV=4, DEBOUNCE=3.
  - Idle with fila=0 -> col sequence 1,2,4,8,1 with each value held 4 cycles; all outputs stay 0.
  - Key row 2, column 1 (fila=4'b0100 while col=4'b0010) held steady -> evt_valid=1, evt_code=9 after the 3rd identical frame, key_held=1. With evt_ready=1 for one cycle, evt_valid drops and no second event follows while the key is held.
  - Bounce: key toggles every 10 cycles for 60 cycles, then is stable -> exactly one event, code 9. No event is raised during the bounce.
  - Keys 0 and 5 held together -> multi_key=1, key_held=0, no event. Releasing key 5 -> single press event with code 0.
  - evt_ready=0 with press 3, release, press 7 -> evt_code stays 3 and evt_overrun=1. A handshake then clears both flags the next cycle.
  - rst_n pulsed low mid-frame while a key is held -> outputs return to reset values immediately, col=1, and the key is re-qualified after 3 full frames.
